// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared types and default sizing for the instruction prefetch buffer.
package pf_pkg;

  localparam int PF_DEPTH  = 16;
  localparam int PF_PEEK   = 4;
  localparam int PF_ADDR_W = 24;

  typedef enum logic [1:0] {
    ST_REDIRECT = 2'd0,
    ST_RUN      = 2'd1,
    ST_STALL    = 2'd2
  } pf_state_e;

  // A word read from an odd address only yields its upper byte.
  function automatic logic [1:0] fetch_len(input logic addr_lsb);
    return addr_lsb ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Word-read bus between the prefetch buffer (master) and instruction memory (slave).
interface instr_prefetch_buffer_if
  import pf_pkg::*;
#(
  parameter int ADDR_W = PF_ADDR_W
);
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ack;
  logic [15:0]       bus_data;

  modport master (output bus_req, bus_addr, input bus_ack, bus_data);
  modport slave  (input bus_req, bus_addr, output bus_ack, bus_data);
endinterface

// File: rtl/instr_prefetch_buffer_byte_ring.sv
// Circular byte store: up to two bytes written per cycle, PEEK-byte window from the oldest byte.
module pf_byte_ring
  import pf_pkg::*;
#(
  parameter int  DEPTH = PF_DEPTH,
  parameter int  PEEK  = PF_PEEK,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              wr_two,
  input  logic [7:0]        wr_byte0,
  input  logic [7:0]        wr_byte1,
  input  logic              rd_en,
  input  logic [2:0]        rd_len,
  input  logic [CW-1:0]     count,
  output logic [8*PEEK-1:0] peek_data
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_ptr_p1;

  assign wr_ptr_p1 = wr_ptr_q + PW'(1);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + (wr_two ? PW'(2) : PW'(1));
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(rd_len);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clear && !reset) begin
      mem_q[wr_ptr_q] <= wr_byte0;
      if (wr_two) mem_q[wr_ptr_p1] <= wr_byte1;
    end
  end

  // Slots beyond the fill level read zero so stale bytes never leak to the decoder.
  for (genvar gi = 0; gi < PEEK; gi++) begin : g_peek
    assign peek_data[8*gi +: 8] = (CW'(gi) < count) ? mem_q[rd_ptr_q + PW'(gi)] : 8'h00;
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: fetch FSM, fill count and fetch address around a byte ring.
module instr_prefetch_buffer
  import pf_pkg::*;
#(
  parameter int  DEPTH  = PF_DEPTH,
  parameter int  PEEK   = PF_PEEK,
  parameter int  ADDR_W = PF_ADDR_W,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        flush_addr,
  instr_prefetch_buffer_if.master  bus,
  input  logic                     pop,
  input  logic [2:0]               pop_len,
  output logic [8*PEEK-1:0]        peek_data,
  output logic [CW-1:0]            count,
  output logic [ADDR_W-1:0]        fetch_addr
);

  pf_state_e         state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              req;
  logic              ack_ok;
  logic              pop_ok;
  logic [1:0]        push_len;
  logic [CW:0]       need_total;
  logic [8*PEEK-1:0] ring_peek;

  assign req      = (state_q == ST_RUN) && !reset;
  assign push_len = fetch_len(fetch_addr_q[0]);
  assign ack_ok   = req && bus.bus_ack && !flush;
  assign pop_ok   = pop && !flush && (pop_len != 3'd0) && (int'(pop_len) <= PEEK)
                    && (CW'(pop_len) <= count_q);

  // RUN is only held while the next fetch is guaranteed to fit, so a push never overflows.
  always_comb begin
    count_d      = count_q;
    fetch_addr_d = fetch_addr_q;
    state_d      = state_q;
    need_total   = '0;
    if (flush) begin
      count_d      = '0;
      fetch_addr_d = flush_addr;
      state_d      = ST_REDIRECT;
    end else begin
      if (ack_ok) begin
        count_d      = count_q + CW'(push_len);
        fetch_addr_d = fetch_addr_q + ADDR_W'(push_len);
      end
      if (pop_ok) count_d = count_d - CW'(pop_len);
      need_total = {1'b0, count_d} + (CW+1)'(fetch_len(fetch_addr_d[0]));
      state_d    = (need_total <= (CW+1)'(DEPTH)) ? ST_RUN : ST_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_REDIRECT;
      count_q      <= '0;
      fetch_addr_q <= flush_addr;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  pf_byte_ring #(
    .DEPTH (DEPTH),
    .PEEK  (PEEK)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .wr_en     (ack_ok),
    .wr_two    (!fetch_addr_q[0]),
    .wr_byte0  (fetch_addr_q[0] ? bus.bus_data[15:8] : bus.bus_data[7:0]),
    .wr_byte1  (bus.bus_data[15:8]),
    .rd_en     (pop_ok),
    .rd_len    (pop_len),
    .count     (count_q),
    .peek_data (ring_peek)
  );

  assign bus.bus_req  = req;
  assign bus.bus_addr = {fetch_addr_q[ADDR_W-1:1], 1'b0};
  assign peek_data    = reset ? '0 : ring_peek;
  assign count        = count_q;
  assign fetch_addr   = fetch_addr_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed self-checking bench for instr_prefetch_buffer (DEPTH=16, PEEK=4, ADDR_W=24).
module tb_instr_prefetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [23:0] flush_addr;
  logic        pop;
  logic [2:0]  pop_len;
  logic [31:0] peek_data;
  logic [4:0]  count;
  logic [23:0] fetch_addr;

  int n_tests = 0;
  int n_fail  = 0;

  instr_prefetch_buffer_if #(.ADDR_W(24)) bus_if ();

  instr_prefetch_buffer #(.DEPTH(16), .PEEK(4), .ADDR_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .flush_addr (flush_addr),
    .bus        (bus_if),
    .pop        (pop),
    .pop_len    (pop_len),
    .peek_data  (peek_data),
    .count      (count),
    .fetch_addr (fetch_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fb(input logic [23:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  initial begin
    int          popped;
    int          cyc;
    int          mcount;
    int          need;
    int          plen;
    int          pushn;
    int          popn;
    logic        exp_req;
    logic        ack_now;
    logic [23:0] mfetch;
    logic [23:0] mrd;
    logic [23:0] base;
    logic [31:0] exp_peek;

    reset = 1'b1; flush = 1'b0; flush_addr = 24'h002100;
    pop = 1'b0; pop_len = 3'd0;
    bus_if.bus_ack = 1'b0; bus_if.bus_data = 16'h0000;

    // Reset state and first two sequential fetches
    step(); step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_peek", peek_data, 32'd0);
    check("rst_fetch", 32'(fetch_addr), 32'h002100);
    reset = 1'b0;
    #1;
    check("redirect_req", 32'(bus_if.bus_req), 32'd0);
    step();
    check("run_req", 32'(bus_if.bus_req), 32'd1);
    check("addr0", 32'(bus_if.bus_addr), 32'h002100);
    bus_if.bus_ack = 1'b1; bus_if.bus_data = 16'hBBAA;
    $display("[TB] ack addr=%06h data=%04h", bus_if.bus_addr, bus_if.bus_data);
    step();
    check("addr1", 32'(bus_if.bus_addr), 32'h002102);
    check("count2", 32'(count), 32'd2);
    check("peek2", peek_data, 32'h0000BBAA);
    bus_if.bus_data = 16'hDDCC;
    $display("[TB] ack addr=%06h data=%04h", bus_if.bus_addr, bus_if.bus_data);
    step();
    bus_if.bus_ack = 1'b0;
    check("count4", 32'(count), 32'd4);
    check("peek4", peek_data, 32'hDDCCBBAA);

    // Odd start address pushes only the upper byte
    reset = 1'b1; flush_addr = 24'h000103;
    step();
    reset = 1'b0;
    step();
    check("odd_addr", 32'(bus_if.bus_addr), 32'h000102);
    bus_if.bus_ack = 1'b1; bus_if.bus_data = 16'h5511;
    $display("[TB] ack addr=%06h data=%04h", bus_if.bus_addr, bus_if.bus_data);
    step();
    bus_if.bus_ack = 1'b0;
    check("odd_count", 32'(count), 32'd1);
    check("odd_peek", peek_data, 32'h00000055);
    check("odd_fetch", 32'(fetch_addr), 32'h000104);
    check("odd_next", 32'(bus_if.bus_addr), 32'h000104);

    // Fill to capacity, stall, ignore ack while stalled
    reset = 1'b1; flush_addr = 24'h000200;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      bus_if.bus_ack  = 1'b1;
      bus_if.bus_data = {8'(8'h11 + 2*i), 8'(8'h10 + 2*i)};
      $display("[TB] ack addr=%06h data=%04h", bus_if.bus_addr, bus_if.bus_data);
      step();
    end
    bus_if.bus_ack = 1'b0;
    check("full_count", 32'(count), 32'd16);
    check("stall_req", 32'(bus_if.bus_req), 32'd0);
    check("full_fetch", 32'(fetch_addr), 32'h000210);
    check("full_peek", peek_data, 32'h13121110);
    bus_if.bus_ack = 1'b1; bus_if.bus_data = 16'hEEEE;
    step();
    bus_if.bus_ack = 1'b0;
    check("stall_ack_ign", 32'(count), 32'd16);
    check("stall_fetch", 32'(fetch_addr), 32'h000210);
    pop = 1'b1; pop_len = 3'd2;
    step();
    pop = 1'b0;
    check("unstall_count", 32'(count), 32'd14);
    check("unstall_req", 32'(bus_if.bus_req), 32'd1);
    check("unstall_peek", peek_data, 32'h15141312);

    // Drain to 3, then simultaneous 2-byte push and 3-byte pop
    pop = 1'b1; pop_len = 3'd4; step();
    step();
    pop_len = 3'd3; step();
    pop = 1'b0;
    check("drain_count", 32'(count), 32'd3);
    check("drain_peek", peek_data, 32'h001F1E1D);
    pop = 1'b1; pop_len = 3'd3;
    bus_if.bus_ack = 1'b1; bus_if.bus_data = 16'h7766;
    $display("[TB] ack addr=%06h data=%04h", bus_if.bus_addr, bus_if.bus_data);
    step();
    pop = 1'b0; bus_if.bus_ack = 1'b0;
    check("ackpop_count", 32'(count), 32'd2);
    check("ackpop_peek", peek_data, 32'h00007766);
    check("ackpop_fetch", 32'(fetch_addr), 32'h000212);

    // Illegal pops leave state untouched
    pop = 1'b1; pop_len = 3'd3; step();
    check("illegal3_count", 32'(count), 32'd2);
    check("illegal3_peek", peek_data, 32'h00007766);
    pop_len = 3'd0; step();
    pop = 1'b0;
    check("illegal0_count", 32'(count), 32'd2);

    // Flush beats ack and pop; a second flush restarts redirect
    flush = 1'b1; flush_addr = 24'h000400;
    bus_if.bus_ack = 1'b1; bus_if.bus_data = 16'h9999;
    pop = 1'b1; pop_len = 3'd1;
    step();
    bus_if.bus_ack = 1'b0; pop = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_peek", peek_data, 32'd0);
    check("flush_req", 32'(bus_if.bus_req), 32'd0);
    check("flush_fetch", 32'(fetch_addr), 32'h000400);
    flush_addr = 24'h000501;
    step();
    flush = 1'b0;
    check("reflush_req", 32'(bus_if.bus_req), 32'd0);
    check("reflush_fetch", 32'(fetch_addr), 32'h000501);
    step();
    check("reflush_run", 32'(bus_if.bus_req), 32'd1);
    check("reflush_addr", 32'(bus_if.bus_addr), 32'h000500);

    // Stream 40 bytes through the ring with mixed pops and gappy acks
    popped = 0; cyc = 0; mcount = 0;
    mfetch = 24'h000501; mrd = 24'h000501;
    while (popped < 40 && cyc < 400) begin
      need    = mfetch[0] ? 1 : 2;
      exp_req = ((16 - mcount) >= need);
      check("wrap_req", 32'(bus_if.bus_req), 32'(exp_req));
      if (exp_req) check("wrap_addr", 32'(bus_if.bus_addr), 32'({mfetch[23:1], 1'b0}));
      check("wrap_count", 32'(count), 32'(mcount));
      exp_peek = 32'd0;
      for (int i = 0; i < 4; i++)
        if (i < mcount) exp_peek[8*i +: 8] = fb(mrd + 24'(i));
      check("wrap_peek", peek_data, exp_peek);
      ack_now = ((cyc % 4) != 3);
      base    = {mfetch[23:1], 1'b0};
      bus_if.bus_ack  = ack_now;
      bus_if.bus_data = {fb(base + 24'd1), fb(base)};
      if (exp_req && ack_now)
        $display("[TB] ack addr=%06h data=%04h", base, bus_if.bus_data);
      plen    = ((cyc / 2) % 4) + 1;
      pop     = ((cyc % 2) == 1) && (mcount >= plen);
      pop_len = 3'(plen);
      pushn   = (exp_req && ack_now) ? need : 0;
      popn    = pop ? plen : 0;
      mcount  = mcount + pushn - popn;
      mfetch  = mfetch + 24'(pushn);
      mrd     = mrd + 24'(popn);
      popped  = popped + popn;
      cyc++;
      step();
    end
    bus_if.bus_ack = 1'b0; pop = 1'b0;
    check("wrap_done", 32'(popped >= 40), 32'd1);

    // Fetch address wraps modulo 2^24
    flush = 1'b1; flush_addr = 24'hFFFFFF;
    step();
    flush = 1'b0;
    step();
    check("top_addr", 32'(bus_if.bus_addr), 32'h00FFFFFE);
    bus_if.bus_ack = 1'b1; bus_if.bus_data = 16'hAB00;
    $display("[TB] ack addr=%06h data=%04h", bus_if.bus_addr, bus_if.bus_data);
    step();
    bus_if.bus_ack = 1'b0;
    check("wrap_fetch", 32'(fetch_addr), 32'h000000);
    check("wrap_byte", peek_data, 32'h000000AB);

    // Reset mid-request: a late ack must not push
    reset = 1'b1; flush_addr = 24'h000800;
    bus_if.bus_ack = 1'b1; bus_if.bus_data = 16'h1234;
    step();
    check("midrst_req", 32'(bus_if.bus_req), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    reset = 1'b0;
    step();
    bus_if.bus_ack = 1'b0;
    check("late_ack_count", 32'(count), 32'd0);
    check("late_ack_fetch", 32'(fetch_addr), 32'h000800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
